counter_nb_mod: RTL and testbench

//   Parametrised N-bit modulo counter; generalises the fixed 2-bit free-running counter.

---
 rtl/counter_nb_mod.sv | 87 ++++++++
 tb/tb_counter_nb_mod.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/counter_nb_mod.sv
// Parametrised N-bit modulo counter with run-time modulus, up/down direction,
// synchronous clear/load, enable prescaler, terminal-count pulse and sticky wrap flag.
module counter_nb_mod #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic [WIDTH-1:0]      modulus,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  ovf_clr,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  ovf
);

  logic [WIDTH-1:0]      r_count;
  logic [WIDTH-1:0]      w_count_nxt;
  logic [PRESCALE_W-1:0] r_pre;
  logic [PRESCALE_W-1:0] w_pre_nxt;
  logic                  r_tc;
  logic                  r_ovf;
  logic                  w_step;
  logic                  w_wrap;

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

  // Next-state: clr beats load beats step; up wraps on count>=modulus so a
  // loaded out-of-range value still returns to 0 on the next up step.
  always_comb begin
    w_count_nxt = r_count;
    w_pre_nxt   = r_pre;
    w_wrap      = 1'b0;
    w_step      = ena && (r_pre == prescale);
    if (clr) begin
      w_count_nxt = {WIDTH{1'b0}};
      w_pre_nxt   = {PRESCALE_W{1'b0}};
    end else if (load) begin
      w_count_nxt = load_val;
      w_pre_nxt   = {PRESCALE_W{1'b0}};
    end else if (w_step) begin
      w_pre_nxt = {PRESCALE_W{1'b0}};
      if (dir) begin
        if (r_count >= modulus) begin
          w_count_nxt = {WIDTH{1'b0}};
          w_wrap      = 1'b1;
        end else begin
          w_count_nxt = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end else begin
        if (r_count == {WIDTH{1'b0}}) begin
          w_count_nxt = modulus;
          w_wrap      = 1'b1;
        end else begin
          w_count_nxt = r_count - {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end else if (ena) begin
      w_pre_nxt = r_pre + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end else begin
      w_pre_nxt = r_pre;
    end
  end

  // State registers; a wrap on the same edge as ovf_clr keeps ovf set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {WIDTH{1'b0}};
      r_pre   <= {PRESCALE_W{1'b0}};
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_pre   <= w_pre_nxt;
      r_tc    <= w_wrap;
      r_ovf   <= w_wrap | (r_ovf & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_counter_nb_mod.sv
// Table-driven scoreboard bench for counter_nb_mod (WIDTH=8, PRESCALE_W=4).
module tb_counter_nb_mod;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic       dir;
  logic [7:0] modulus;
  logic [3:0] prescale;
  logic       ovf_clr;
  logic [7:0] count;
  logic       tc;
  logic       ovf;

  int total;
  int bad;

  typedef struct {
    string      tag;
    logic       ena;
    logic       clr;
    logic       load;
    logic [7:0] lv;
    logic       dir;
    logic [7:0] md;
    logic [3:0] ps;
    logic       oc;
    logic [7:0] e_count;
    logic       e_tc;
    logic       e_ovf;
  } vec_t;

  vec_t tab[$];
  vec_t exp_q[$];

  counter_nb_mod #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .load(load),
    .load_val(load_val), .dir(dir), .modulus(modulus), .prescale(prescale),
    .ovf_clr(ovf_clr), .count(count), .tc(tc), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input string tag, input logic e, input logic c,
                              input logic l, input logic [7:0] lv, input logic d,
                              input logic [7:0] md, input logic [3:0] ps,
                              input logic oc, input logic [7:0] ec,
                              input logic et, input logic eo);
    vec_t v;
    v.tag = tag; v.ena = e; v.clr = c; v.load = l; v.lv = lv; v.dir = d;
    v.md = md; v.ps = ps; v.oc = oc; v.e_count = ec; v.e_tc = et; v.e_ovf = eo;
    tab.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    ena = v.ena; clr = v.clr; load = v.load; load_val = v.lv; dir = v.dir;
    modulus = v.md; prescale = v.ps; ovf_clr = v.oc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, ".count"}, int'(count), int'(e.e_count));
    chk({e.tag, ".tc"},    int'(tc),    int'(e.e_tc));
    chk({e.tag, ".ovf"},   int'(ovf),   int'(e.e_ovf));
  endtask

  initial begin
    total = 0; bad = 0;
    // Up count 0..9 with a single wrap, prescale 0
    for (int i = 1; i <= 9; i++) add("up9", 1, 0, 0, 0, 1, 9, 0, 0, 8'(i), 0, 0);
    add("up9_wrap", 1, 0, 0, 0, 1, 9, 0, 0, 0, 1, 1);
    add("up9_after", 1, 0, 0, 0, 1, 9, 0, 0, 1, 0, 1);
    // Load 3, count down modulo 5
    add("dn_load", 1, 0, 1, 3, 0, 5, 0, 0, 3, 0, 1);
    add("dn", 1, 0, 0, 0, 0, 5, 0, 0, 2, 0, 1);
    add("dn", 1, 0, 0, 0, 0, 5, 0, 0, 1, 0, 1);
    add("dn", 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 1);
    add("dn_wrap", 1, 0, 0, 0, 0, 5, 0, 0, 5, 1, 1);
    add("dn_after", 1, 0, 0, 0, 0, 5, 0, 1, 4, 0, 0);
    add("dn", 1, 0, 0, 0, 0, 5, 0, 0, 3, 0, 0);
    add("dn", 1, 0, 0, 0, 0, 5, 0, 0, 2, 0, 0);
    add("dn", 1, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0);
    add("dn", 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    // ovf_clr coinciding with a wrap: set wins; then clear alone
    add("ovf_set_wins", 1, 0, 0, 0, 0, 5, 0, 1, 5, 1, 1);
    add("ovf_clr_alone", 1, 0, 0, 0, 0, 5, 0, 1, 4, 0, 0);
    // clr beats load; load out-of-range then up wrap
    add("clr_over_load", 1, 1, 1, 7, 0, 5, 0, 0, 0, 0, 0);
    add("load200", 1, 0, 1, 200, 1, 9, 0, 0, 200, 0, 0);
    add("up_from_200", 1, 0, 0, 0, 1, 9, 0, 0, 0, 1, 1);
    add("up_after", 1, 0, 0, 0, 1, 9, 0, 0, 1, 0, 1);
    add("ena_low_hold", 0, 0, 0, 0, 1, 9, 0, 0, 1, 0, 1);
    add("load200_dn", 1, 0, 1, 200, 0, 9, 0, 0, 200, 0, 1);
    add("dn_above_mod", 1, 0, 0, 0, 0, 9, 0, 0, 199, 0, 1);
    add("dn_above_mod", 1, 0, 0, 0, 0, 9, 0, 0, 198, 0, 1);
    // modulus 0: hold 0 and pulse tc on every step
    add("clr_keeps_ovf", 1, 1, 0, 0, 0, 9, 0, 0, 0, 0, 1);
    add("mod0_up", 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    add("mod0_dn", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add("mod0_noena", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Full natural wrap with modulus 255
    add("full_load", 1, 0, 1, 254, 1, 255, 0, 0, 254, 0, 1);
    add("full_up", 1, 0, 0, 0, 1, 255, 0, 0, 255, 0, 1);
    add("full_up_wrap", 1, 0, 0, 0, 1, 255, 0, 0, 0, 1, 1);
    add("full_dn_wrap", 1, 0, 0, 0, 0, 255, 0, 0, 255, 1, 1);
    add("full_dn", 1, 0, 0, 0, 0, 255, 0, 1, 254, 0, 0);
    // Prescale 2: step every 3rd enabled cycle, phase kept across ena low
    add("ps_clr", 1, 1, 0, 0, 1, 9, 2, 0, 0, 0, 0);
    add("ps", 1, 0, 0, 0, 1, 9, 2, 0, 0, 0, 0);
    add("ps", 1, 0, 0, 0, 1, 9, 2, 0, 0, 0, 0);
    add("ps_step", 1, 0, 0, 0, 1, 9, 2, 0, 1, 0, 0);
    add("ps", 1, 0, 0, 0, 1, 9, 2, 0, 1, 0, 0);
    add("ps_frozen", 0, 0, 0, 0, 1, 9, 2, 0, 1, 0, 0);
    add("ps_frozen", 0, 0, 0, 0, 1, 9, 2, 0, 1, 0, 0);
    add("ps_resume", 1, 0, 0, 0, 1, 9, 2, 0, 1, 0, 0);
    add("ps_step", 1, 0, 0, 0, 1, 9, 2, 0, 2, 0, 0);
    add("ps", 1, 0, 0, 0, 1, 9, 2, 0, 2, 0, 0);
    add("ps", 1, 0, 0, 0, 1, 9, 2, 0, 2, 0, 0);
    add("ps_step", 1, 0, 0, 0, 1, 9, 2, 0, 3, 0, 0);
    add("load_noena", 0, 0, 1, 5, 1, 9, 2, 0, 5, 0, 0);

    rst_n = 1'b0; ena = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'd0;
    dir = 1'b1; modulus = 8'd9; prescale = 4'd0; ovf_clr = 1'b0;
    #12;
    chk("rst.count", int'(count), 0);
    chk("rst.tc", int'(tc), 0);
    chk("rst.ovf", int'(ovf), 0);
    rst_n = 1'b1;

    for (int i = 0; i < tab.size(); i++) apply(tab[i]);

    // Hand sequence: wrap to set ovf, count to 5, then async reset mid-cycle
    begin
      vec_t v;
      v.tag = "pre_rst_load"; v.ena = 1; v.clr = 0; v.load = 1; v.lv = 9; v.dir = 1;
      v.md = 9; v.ps = 0; v.oc = 0; v.e_count = 9; v.e_tc = 0; v.e_ovf = 0;
      apply(v);
      v.tag = "pre_rst_wrap"; v.load = 0; v.e_count = 0; v.e_tc = 1; v.e_ovf = 1;
      apply(v);
      for (int k = 1; k <= 5; k++) begin
        v.tag = "pre_rst_up"; v.e_count = 8'(k); v.e_tc = 0; v.e_ovf = 1;
        apply(v);
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst.count", int'(count), 0);
      chk("async_rst.tc", int'(tc), 0);
      chk("async_rst.ovf", int'(ovf), 0);
      #1;
      rst_n = 1'b1;
      v.tag = "post_rst"; v.e_count = 1; v.e_tc = 0; v.e_ovf = 0;
      apply(v);
      v.tag = "post_rst"; v.e_count = 2;
      apply(v);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
